// File: rtl/word_offset_encoder.sv
// Serialises an 8-bit word-enable mask into binary word offsets, lowest set bit first.
// One offset per output handshake. A new mask may be accepted on the last beat of the current one.
//
// state | meaning
// IDLE  | no mask held; ready for a new mask
// BUSY  | draining rem; out_offset shows the lowest remaining bit
module word_offset_encoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_mask,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_offset,
  output logic       out_last,
  output logic       err_empty
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [7:0] rem;
  logic [7:0] rem_clr;
  logic [2:0] low_idx;
  logic       in_fire;
  logic       out_fire;

  assign rem_clr = rem & (rem - 8'd1);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rem[i]) low_idx = 3'(i);
    end
  end

  assign out_valid  = (state == BUSY);
  assign out_last   = out_valid && (rem_clr == 8'd0);
  assign out_offset = out_valid ? low_idx : 3'd0;
  assign out_fire   = out_valid && out_ready;
  assign in_ready   = (state == IDLE) || (out_fire && out_last);
  assign in_fire    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem       <= 8'd0;
      err_empty <= 1'b0;
    end else begin
      err_empty <= 1'b0;
      if (out_fire) begin
        if (out_last) begin
          state <= IDLE;
          rem   <= 8'd0;
        end else begin
          rem <= rem_clr;
        end
      end
      // An input accept overrides the last-beat return to IDLE.
      if (in_fire) begin
        if (in_mask != 8'd0) begin
          state <= BUSY;
          rem   <= in_mask;
        end else begin
          state     <= IDLE;
          rem       <= 8'd0;
          err_empty <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_word_offset_encoder.sv
// Directed bench for word_offset_encoder: expected beats are queued on issue and
// checked by an independent monitor whenever an output handshake occurs.
module tb_word_offset_encoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_mask;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_offset;
  logic       out_last;
  logic       err_empty;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [3:0] exp_q[$];   // {last, offset}
  int         beat_cyc[$];

  word_offset_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mask    (in_mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_offset (out_offset),
    .out_last   (out_last),
    .err_empty  (err_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares each output handshake against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      beat_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got offset %0d with nothing expected", out_offset);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("beat_offset", {5'd0, out_offset}, {5'd0, e[2:0]});
        check("beat_last", {7'd0, out_last}, {7'd0, e[3]});
        check("ready_on_last", {7'd0, in_ready}, {7'd0, e[3]});
      end
    end
  end

  task automatic send(input logic [7:0] m, input bit hold);
    int hi;
    int n;
    hi = -1;
    for (int i = 0; i < 8; i++) if (m[i]) hi = i;
    for (int i = 0; i < 8; i++) if (m[i]) exp_q.push_back({(i == hi), 3'(i)});
    in_mask  = m;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0 for mask %0h", m);
    end
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_contig(input string name, input int n);
    if (beat_cyc.size() != n) begin
      check(name, 8'(beat_cyc.size()), 8'(n));
    end else begin
      check(name, 8'(beat_cyc[n-1] - beat_cyc[0]), 8'(n - 1));
    end
    beat_cyc.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mask   = 8'h00;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", {7'd0, in_ready}, 8'd1);
    check("rst_out_valid", {7'd0, out_valid}, 8'd0);
    check("rst_out_offset", {5'd0, out_offset}, 8'd0);
    check("rst_out_last", {7'd0, out_last}, 8'd0);
    check("rst_err_empty", {7'd0, err_empty}, 8'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(8'h01, 0); wait_drain();
    send(8'h80, 0); wait_drain();
    beat_cyc.delete();

    send(8'hA5, 0); wait_drain();
    check_contig("a5_contiguous", 4);

    // Backpressure: head beat must hold stable.
    out_ready = 1'b0;
    send(8'h06, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_valid", {7'd0, out_valid}, 8'd1);
      check("bp_offset", {5'd0, out_offset}, 8'd1);
      check("bp_last", {7'd0, out_last}, 8'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();
    beat_cyc.delete();

    send(8'h00, 0);
    @(negedge clk);
    check("empty_err_hi", {7'd0, err_empty}, 8'd1);
    check("empty_no_valid", {7'd0, out_valid}, 8'd0);
    check("empty_ready", {7'd0, in_ready}, 8'd1);
    @(negedge clk);
    check("empty_err_lo", {7'd0, err_empty}, 8'd0);
    check("empty_no_valid2", {7'd0, out_valid}, 8'd0);
    @(posedge clk);
    #1;

    send(8'h03, 1); send(8'h40, 0); wait_drain();
    check_contig("b2b_no_bubble", 3);

    send(8'hFF, 0); wait_drain();
    check_contig("ff_contiguous", 8);

    // Reset mid-drain.
    send(8'hFF, 0);
    begin
      int n;
      n = 0;
      while (exp_q.size() > 5 && n < 30) begin
        @(negedge clk);
        #2;
        n++;
      end
    end
    check("pre_reset_valid", {7'd0, out_valid}, 8'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {7'd0, out_valid}, 8'd0);
    check("async_rst_offset", {5'd0, out_offset}, 8'd0);
    check("async_rst_last", {7'd0, out_last}, 8'd0);
    check("async_rst_ready", {7'd0, in_ready}, 8'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    beat_cyc.delete();
    @(negedge clk);
    check("post_rst_ready", {7'd0, in_ready}, 8'd1);
    check("post_rst_valid", {7'd0, out_valid}, 8'd0);
    @(posedge clk);
    #1;
    send(8'h10, 0); wait_drain();
    check_contig("single_after_rst", 1);

    repeat (3) @(posedge clk);
    check("leftover_beats", 8'(exp_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule

// File: doc/word_offset_encoder.md
# word_offset_encoder

Sequential inverse of the cache word-offset decoder. Accepts an 8-bit word-enable mask (one-hot or multi-hot) over a valid/ready handshake and emits one 3-bit binary word offset per output handshake, lowest set bit first, until the mask is drained. Sits between the cache fill/write-back logic, which builds word masks, and the data-array port, which consumes binary offsets.

## Interface

- Parameters: none. Widths are fixed: 8-bit mask, 3-bit offset, matching the 8-word cache block.
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_mask is presented
- in_ready  out  1  block can accept a mask this cycle
- in_mask  in  8  word-enable mask; bit i selects word offset i
- out_valid  out  1  out_offset is valid
- out_ready  in  1  consumer takes out_offset this cycle
- out_offset  out  3  binary offset of the lowest remaining set bit
- out_last  out  1  current beat is the final one for this mask
- err_empty  out  1  one-cycle pulse: an all-zero mask was accepted

## Operation

- Storage: state (IDLE/BUSY), rem[7:0] (remaining bits), err_empty register.
- Input handshake: an input fires when in_valid && in_ready.
- IDLE:
  - in_ready = 1.
  - On an input fire with in_mask != 0: rem <= in_mask, go to BUSY.
  - On an input fire with in_mask == 0: stay in IDLE, rem stays 0, err_empty <= 1 for exactly one cycle. No output beat is produced.
- BUSY:
  - out_valid = 1.
  - out_offset = index of the lowest set bit of rem, priority-encoded from the register only (no input path).
  - out_last = 1 when rem has exactly one bit set, i.e. (rem & (rem-1)) == 0.
- Output fire (out_valid && out_ready):
  - rem <= rem & (rem-1), clearing the lowest set bit.
  - If out_last: go to IDLE, rem <= 0.
- Back-to-back: in_ready = (state==IDLE) || (out_valid && out_ready && out_last).
  - If an input fires on the last-beat cycle, rem loads the new mask and the block stays in BUSY (or returns to IDLE with err_empty if the new mask is 0).
  - in_ready therefore depends combinationally on out_ready; this is the only such path.
- No output fire: rem, out_offset and out_last hold unchanged. Backpressure must never change offset order.
- Bits are emitted in strictly ascending offset order. Beat count equals popcount(in_mask), from 1 to 8.
- Reset (asynchronous, any time, including mid-drain):
  - state = IDLE, rem = 0, err_empty = 0.
  - Any remaining beats are discarded.
- Reset values of outputs: in_ready = 1, out_valid = 0, out_offset = 0, out_last = 0, err_empty = 0. out_offset and out_last are forced to 0 whenever out_valid = 0.

## Timing

- Latency: mask accepted at edge N, first beat valid in the cycle after edge N. No combinational path from in_mask to any output.
- Throughput: one beat per cycle while out_ready = 1. A mask with k bits drains in k cycles.
- With back-to-back input, the first beat of the next mask follows its predecessor's last beat with zero bubble cycles.
- err_empty is high during the cycle after the zero-mask accept edge, then low.

## Test plan

- Single bit: in_mask=8'h01 → one beat, out_offset=0, out_last=1. in_mask=8'h80 → one beat, out_offset=7, out_last=1.
- Multi-bit, out_ready held at 1: in_mask=8'hA5 → offsets 0, 2, 5, 7 on four consecutive cycles. out_last=1 only with offset 7, and in_ready=1 in that same cycle.
- Backpressure: in_mask=8'h06, out_ready=0 for 3 cycles → out_offset=1 held stable with out_last=0. Then out_ready=1 → offsets 1, 2, and out_last=1 on offset 2.
- Empty mask: in_mask=8'h00 accepted → err_empty=1 for exactly one cycle, out_valid stays 0, in_ready stays 1.
- Back-to-back: 8'h03 then 8'h40, with in_valid held and out_ready=1 → offsets 0, 1, 6 on three consecutive cycles with no bubble. 8'hFF → eight beats, offsets 0 through 7.
- Reset mid-drain: in_mask=8'hFF, assert rst_n low after 3 beats → out_valid=0 and out_offset=0 immediately, without waiting for clk. After release, in_ready=1; in_mask=8'h10 → single beat with offset 4.
